axi_burst_wr_master: RTL and testbench
======================================

// Module: axi_burst_wr_master
// PURPOSE
// - AXI4 write master feeding the axi_ram slave through the IfAxi write channels (AW/W/B).
// - Turns one command (addr, len, id) plus a beat stream into one INCR burst, then returns one completion.
// - Replaces hand-driven clocking-block write sequences in benches and serves as the RTL write path to the SRAM.
// PARAMETERS
// ID_WIDTH     4    awid/bid width
// ADDR_WIDTH   32   byte address width
// DATA_WIDTH   32   W data width; power of 2, >= 8
// LEN_WIDTH    8    awlen width (beats-1)
// (STRB_WIDTH = DATA_WIDTH/8; SIZE = log2(STRB_WIDTH), fixed)
// PORTS
// aclk        in   1           clock, all logic on rising edge
// areset      in   1           asynchronous reset, active-high
// cmd_valid   in   1           command request
// cmd_ready   out  1           command accepted when valid&&ready
// cmd_addr    in   ADDR_WIDTH  burst start byte address
// cmd_len     in   LEN_WIDTH   beats-1
// cmd_id      in   ID_WIDTH    transaction id
// in_valid    in   1           write beat available
// in_ready    out  1           write beat consumed when valid&&ready
// in_data     in   DATA_WIDTH  beat data
// in_strb     in   STRB_WIDTH  beat byte strobes
// done_valid  out  1           completion available; held until done_ready
// done_ready  in   1           completion consumer ready
// done_resp   out  2           final response (AXI encoding)
// done_id     out  ID_WIDTH    id of completed command
// awid/awaddr/awlen/awsize/awburst/awvalid out, awready in  -- AXI AW
// wdata/wstrb/wlast/wvalid out, wready in                   -- AXI W
// bid/bresp/bvalid in, bready out                           -- AXI B
// BEHAVIOUR
// - Reset: state IDLE; awvalid,wvalid,bready,done_valid,cmd_ready=0; beat counter, aw_done, w_done=0;
//   awid/awaddr/awlen/done_id/done_resp=0; awsize=log2(STRB_WIDTH), awburst=2'b01 (constants).
//   Reset mid-burst abandons it immediately; no completion is produced.
// - FSM: IDLE -> BURST -> RESP -> DONE -> IDLE; IDLE -> DONE on rejected command.
// - IDLE: cmd_ready=1. On accept (cycle N) latch addr/len/id. Reject if addr not aligned to
//   STRB_WIDTH or burst crosses 4KB (addr[11:0] + (len+1)*STRB_WIDTH > 4096): go DONE, done_resp=2'b10,
//   no AXI traffic, no beats consumed. Otherwise go BURST; awvalid=1 registered from cycle N+1.
// - BURST: AW and W proceed independently. awvalid held with stable fields until awready (aw_done=1).
//   W is a pass-through: wvalid=in_valid&&!w_done, in_ready=wready&&!w_done, wdata/wstrb=in_*,
//   wlast=(beat_cnt==len). beat_cnt increments per W handshake; handshake with wlast sets w_done.
//   W beats may precede the AW handshake. Exit to RESP when aw_done&&w_done (same-cycle completion allowed).
// - RESP: bready=1 (registered state decode). On bvalid: done_resp=bresp, but 2'b10 if bid!=latched id; -> DONE.
// - DONE: done_valid=1, done_id=latched id; fields stable until done_ready; then -> IDLE, cmd_ready=1 next cycle.
// - Minimum latency (all readies high, len=0): cmd accept N, AW+W at N+1, RESP N+2, B at N+2 earliest, done_valid N+3.
// - One outstanding burst; no commands accepted outside IDLE. bvalid outside RESP is ignored (not consumed).
// - beat_cnt is LEN_WIDTH bits; len=255 gives 256 beats, no wrap before wlast.
// TESTING
// - Single beat: addr=0x10,len=0,id=3,data=0xDEADBEEF,strb=0xF -> one AW(awlen=0), wlast=1, done_resp=0,done_id=3; mem[4]=DEADBEEF.
// - 16-beat burst at 0x100, awready delayed 5 cycles, W beats first -> 16 W beats, wlast only on 16th; mem[0x40..0x4F] written.
// - in_valid toggled every other cycle, wready random -> beat order/data preserved, exactly len+1 W handshakes.
// - 4KB cross: addr=0xFF8,len=3 -> no awvalid, done_resp=2'b10 within 2 cycles; unaligned addr=0x2 same result.
// - strb=4'b0101 over preloaded 0xFFFFFFFF with data 0 -> mem reads 0xFF00FF00; done_ready held low 4 cycles -> done fields stable.
// - areset pulsed at beat 3 of 8 -> all outputs 0 asynchronously, IDLE after release, next command completes normally.

Source files
------------

// File: rtl/axi_burst_wr_master.sv
// AXI4 write master: one command plus a beat stream becomes one INCR burst and one completion.
// Bursts that are unaligned or cross a 4KB page are rejected locally with SLVERR and no bus traffic.
module axi_burst_wr_master #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_strb,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [1:0]              done_resp,
    output logic [ID_WIDTH-1:0]     done_id,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [LEN_WIDTH-1:0]    awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(STRB_WIDTH);
    localparam int XW         = LEN_WIDTH + SIZE + 14;

    typedef enum logic [1:0] {IDLE, BURST, RESP, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [1:0]            done_resp_q, done_resp_d;
    logic                  awvalid_q, awvalid_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  in_burst, w_hs, cmd_bad;
    logic [XW-1:0]         burst_end;

    // End offset within the page, one past the last byte of the burst.
    assign burst_end = XW'(cmd_addr[11:0]) + ((XW'(cmd_len) + XW'(1)) << SIZE);
    assign cmd_bad   = ((cmd_addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0) || (burst_end > XW'(4096));

    assign in_burst   = (state_q == BURST);
    assign wvalid     = in_burst && in_valid && !w_done_q;
    assign in_ready   = in_burst && wready && !w_done_q;
    assign wlast      = in_burst && (beat_cnt_q == len_q);
    assign wdata      = in_data;
    assign wstrb      = in_strb;
    assign w_hs       = wvalid && wready;
    assign awvalid    = awvalid_q;
    assign awaddr     = addr_q;
    assign awlen      = len_q;
    assign awid       = id_q;
    assign awsize     = 3'(SIZE);
    assign awburst    = 2'b01;
    assign bready     = (state_q == RESP);
    assign done_valid = (state_q == DONE);
    assign done_resp  = done_resp_q;
    assign done_id    = id_q;
    assign cmd_ready  = cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        id_d        = id_q;
        beat_cnt_d  = beat_cnt_q;
        done_resp_d = done_resp_q;
        awvalid_d   = awvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                addr_d     = cmd_addr;
                len_d      = cmd_len;
                id_d       = cmd_id;
                beat_cnt_d = '0;
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
                if (cmd_bad) begin
                    state_d     = DONE;
                    done_resp_d = 2'b10;
                end else begin
                    state_d     = BURST;
                    awvalid_d   = 1'b1;
                    done_resp_d = 2'b00;
                end
            end
            BURST: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (wlast) w_done_d = 1'b1;
                end
                // Both channels may finish on the same edge.
                if (aw_done_d && w_done_d) state_d = RESP;
            end
            RESP: if (bvalid) begin
                done_resp_d = (bid == id_q) ? bresp : 2'b10;
                state_d     = DONE;
            end
            DONE: if (done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            beat_cnt_q  <= '0;
            done_resp_q <= 2'b00;
            awvalid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            id_q        <= id_d;
            beat_cnt_q  <= beat_cnt_d;
            done_resp_q <= done_resp_d;
            awvalid_q   <= awvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_wr_master.sv
// Bench for axi_burst_wr_master: AXI slave/RAM model, scoreboard queues for AW, W and completions.
module tb_axi_burst_wr_master;
    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic        done_valid, done_ready;
    logic [1:0]  done_resp;
    logic [3:0]  done_id;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_burst_wr_master dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_strb(in_strb),
        .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp), .done_id(done_id),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; } aw_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } done_t;

    aw_t   exp_aw[$];
    w_t    exp_w[$];
    done_t exp_done[$];

    int total = 0, bad = 0, cyc = 0, acc_cyc = 0, done_cyc = 0;
    int aw_hs_cnt = 0, w_hs_cnt = 0, aw_vld_cyc = 0;
    bit done_seen = 0, abort_beats = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        bad++;
        $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    endtask

    // Slave / RAM model: buffers W beats, commits them once AW and the last beat have arrived.
    logic [31:0] mem [0:1023];
    logic [35:0] wbuf[$];
    bit          s_aw_got = 0, s_wl_got = 0, s_b_done = 0, w_rand = 0, bad_bid = 0;
    logic [31:0] s_addr;
    logic [3:0]  s_id;
    int          s_aw_wait = 0, aw_delay = 0;

    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    end

    always begin
        @(negedge aclk);
        if (areset) begin
            s_aw_got = 0; s_wl_got = 0; s_b_done = 0; s_aw_wait = 0;
            wbuf.delete();
            bvalid = 1'b0; awready = 1'b0;
        end else begin
            if (awvalid && awready) begin s_aw_got = 1; s_addr = awaddr; s_id = awid; end
            if (wvalid && wready) begin wbuf.push_back({wstrb, wdata}); if (wlast) s_wl_got = 1; end
            if (bvalid && bready) s_b_done = 1;
        end
        @(posedge aclk); #1;
        if (s_b_done) begin bvalid = 1'b0; s_b_done = 0; end
        awready = awvalid && !s_aw_got && (s_aw_wait >= aw_delay);
        if (awvalid && !s_aw_got && !awready) s_aw_wait++;
        wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (s_aw_got && s_wl_got && !bvalid) begin
            foreach (wbuf[k])
                for (int b = 0; b < 4; b++)
                    if (wbuf[k][32+b]) mem[(s_addr >> 2) + k][8*b +: 8] = wbuf[k][8*b +: 8];
            wbuf.delete();
            bvalid = 1'b1;
            bid    = bad_bid ? (s_id ^ 4'h1) : s_id;
            bresp  = 2'b00;
            s_aw_got = 0; s_wl_got = 0; s_aw_wait = 0;
        end
    end

    // Monitor: pops and compares on every handshake the DUT presents.
    always @(negedge aclk) begin
        aw_t   a;
        w_t    w;
        done_t d;
        if (!areset) begin
            if (awvalid) aw_vld_cyc++;
            if (awvalid && awready) begin
                aw_hs_cnt++;
                if (exp_aw.size() == 0) fail("aw_unexpected", awaddr, 0);
                else begin
                    a = exp_aw.pop_front();
                    check("awaddr", awaddr, a.addr);
                    check("awlen", awlen, a.len);
                    check("awid", awid, a.id);
                    check("awsize", awsize, 3'd2);
                    check("awburst", awburst, 2'b01);
                end
            end
            if (wvalid && wready) begin
                w_hs_cnt++;
                if (exp_w.size() == 0) fail("w_unexpected", wdata, 0);
                else begin
                    w = exp_w.pop_front();
                    check("wdata", wdata, w.data);
                    check("wstrb", wstrb, w.strb);
                    check("wlast", wlast, w.last);
                end
            end
            if (done_valid) begin
                if (!done_seen) begin done_seen = 1; done_cyc = cyc; end
                if (exp_done.size() == 0) fail("done_unexpected", done_id, 0);
                else begin
                    d = exp_done[0];
                    check("done_resp", done_resp, d.resp);
                    check("done_id", done_id, d.id);
                    if (done_ready) begin void'(exp_done.pop_front()); done_seen = 0; end
                end
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        bit hs = 0;
        int g = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_id = id;
        while (!hs && g < 300) begin
            @(negedge aclk); hs = cmd_ready;
            @(posedge aclk); #1; g++;
        end
        if (!hs) fail("cmd_timeout", 0, 1);
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_beats(input int n, input logic [31:0] base, input logic [3:0] strb, input bit toggle);
        bit hs;
        int g;
        for (int i = 0; i < n && !abort_beats; i++) begin
            if (toggle && i > 0) begin in_valid = 1'b0; @(posedge aclk); #1; end
            in_valid = 1'b1; in_data = base + i; in_strb = strb;
            hs = 0; g = 0;
            while (!hs && !abort_beats && g < 300) begin
                @(negedge aclk); hs = in_ready;
                @(posedge aclk); #1; g++;
            end
            if (!hs && !abort_beats) fail("beat_timeout", i, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                                input logic [31:0] base, input logic [3:0] strb, input logic [1:0] resp);
        aw_t a;
        w_t w;
        done_t d;
        a.addr = addr; a.len = len; a.id = id;
        exp_aw.push_back(a);
        for (int i = 0; i <= int'(len); i++) begin
            w.data = base + i; w.strb = strb; w.last = (i == int'(len));
            exp_w.push_back(w);
        end
        d.resp = resp; d.id = id;
        exp_done.push_back(d);
    endtask

    task automatic wait_done(input int budget);
        int g = 0;
        while (exp_done.size() != 0 && g < budget) begin @(posedge aclk); #1; g++; end
        if (exp_done.size() != 0) begin fail("done_timeout", exp_done.size(), 0); exp_done.delete(); end
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
    endtask

    task automatic burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input logic [31:0] base, input logic [3:0] strb, input bit toggle, input logic [1:0] resp);
        expect_burst(addr, len, id, base, strb, resp);
        fork
            send_cmd(addr, len, id);
            drive_beats(int'(len) + 1, base, strb, toggle);
        join
        wait_done(600);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic reject(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        done_t d;
        int aw0, w0, v0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; v0 = aw_vld_cyc;
        d.resp = 2'b10; d.id = id;
        exp_done.push_back(d);
        in_valid = 1'b1; in_data = 32'h12345678; in_strb = 4'hF;
        send_cmd(addr, len, id);
        wait_done(50);
        in_valid = 1'b0;
        check("rej_latency_ok", (done_cyc - acc_cyc) <= 1, 1);
        check("rej_no_awvalid", aw_vld_cyc - v0, 0);
        check("rej_no_aw", aw_hs_cnt - aw0, 0);
        check("rej_no_beats", w_hs_cnt - w0, 0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awvalid"}, awvalid, 0);
        check({tag, "_wvalid"}, wvalid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wlast"}, wlast, 0);
        check({tag, "_bready"}, bready, 0);
        check({tag, "_done_valid"}, done_valid, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_awaddr"}, awaddr, 0);
        check({tag, "_awid_awlen"}, {awid, awlen}, 0);
        check({tag, "_done_fields"}, {done_id, done_resp}, 0);
        check({tag, "_awsize"}, awsize, 3'd2);
        check({tag, "_awburst"}, awburst, 2'b01);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, g;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        areset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        in_valid = 1'b0; in_data = '0; in_strb = '0; done_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_idle_outputs("reset");
        areset = 1'b0;
        @(posedge aclk); #1;
        check("cmd_ready_after_reset", cmd_ready, 1);

        // Single beat with minimum-latency timing.
        burst(32'h10, 8'd0, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 2'b00);
        check("single_latency", done_cyc - acc_cyc, 2);
        check("single_mem", mem[4], 32'hDEADBEEF);

        // 16 beats with AW held back, so W runs ahead.
        aw_delay = 5;
        burst(32'h100, 8'd15, 4'd1, 32'h1000, 4'hF, 1'b0, 2'b00);
        aw_delay = 0;
        for (int i = 0; i < 16; i++) check("burst16_mem", mem[32'h40 + i], 32'h1000 + i);

        // Gappy beat source and random wready.
        w_rand = 1;
        w0 = w_hs_cnt;
        burst(32'h200, 8'd7, 4'd5, 32'hA5000000, 4'hF, 1'b1, 2'b00);
        w_rand = 0;
        check("toggle_w_count", w_hs_cnt - w0, 8);
        for (int i = 0; i < 8; i++) check("toggle_mem", mem[32'h80 + i], 32'hA5000000 + i);

        // Page crossing and misalignment are refused; ending exactly at the page edge is fine.
        reject(32'hFF8, 8'd3, 4'd6);
        reject(32'h2, 8'd0, 4'd7);
        burst(32'hFF0, 8'd3, 4'd2, 32'hB0, 4'hF, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) check("edge_mem", mem[32'h3FC + i], 32'hB0 + i);

        // Partial strobes, completion held for 4 cycles.
        mem[32'hC0] = 32'hFFFFFFFF;
        done_ready = 1'b0;
        expect_burst(32'h300, 8'd0, 4'd8, 32'h0, 4'b0101, 2'b00);
        fork
            send_cmd(32'h300, 8'd0, 4'd8);
            drive_beats(1, 32'h0, 4'b0101, 1'b0);
        join
        g = 0;
        while (!done_valid && g < 50) begin @(posedge aclk); #1; g++; end
        check("stall_done_valid", done_valid, 1);
        repeat (4) @(posedge aclk);
        #1;
        check("stall_still_valid", done_valid, 1);
        done_ready = 1'b1;
        wait_done(20);
        check("strb_mem", mem[32'hC0], 32'hFF00FF00);

        // Response id mismatch reported as SLVERR.
        bad_bid = 1;
        burst(32'h400, 8'd0, 4'd9, 32'h55AA55AA, 4'hF, 1'b0, 2'b10);
        bad_bid = 0;

        // Reset during beat 3 of 8 abandons the burst.
        expect_burst(32'h500, 8'd7, 4'd4, 32'hC000, 4'hF, 2'b00);
        w0 = w_hs_cnt;
        fork
            send_cmd(32'h500, 8'd7, 4'd4);
            drive_beats(8, 32'hC000, 4'hF, 1'b0);
            begin
                g = 0;
                while (w_hs_cnt < w0 + 3 && g < 300) begin @(posedge aclk); #1; g++; end
                check("rst_at_beat3", w_hs_cnt - w0, 3);
                #2;
                areset = 1'b1;
                abort_beats = 1;
                #1;
                check_idle_outputs("midrst");
                exp_aw.delete(); exp_w.delete(); exp_done.delete();
                @(posedge aclk); #1;
                areset = 1'b0;
            end
        join
        abort_beats = 0;
        @(posedge aclk); #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_no_commit", mem[32'h140], 32'h0);
        burst(32'h600, 8'd1, 4'hA, 32'h600D0000, 4'hF, 1'b0, 2'b00);
        check("post_rst_mem0", mem[32'h180], 32'h600D0000);
        check("post_rst_mem1", mem[32'h181], 32'h600D0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
